dcache_sram_nway: RTL and testbench
===================================

Name: dcache_sram_nway

Overview:
Parametrised N-way set-associative data-cache storage array with per-set true-LRU replacement, per-line valid/dirty bits and a multi-cycle flush (invalidate-all) sequencer. Successor of the fixed 2-way, 16-set cache SRAM. Sits between the dcache controller FSM and the line-fill/write-back path. Lookup is combinational. All state updates occur on clk_i.

Parameters:
WAYS, 2, associativity; power of two, 2..8
SETS, 16, number of sets; power of two, >=2
TAG_W, 23, stored tag width; valid and dirty are held as separate bits
LINE_W, 256, cache line width in bits
IDX_W, $clog2(SETS), set index width (derived)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-low reset
req_i  in  1  access request; ignored while busy_o=1
write_i  in  1  1=write/fill, 0=read lookup
addr_i  in  IDX_W  set index
tag_i  in  TAG_W  lookup/write tag
data_i  in  LINE_W  write/fill line
dirty_i  in  1  dirty value stored on write
flush_i  in  1  start invalidate-all sweep (1-cycle pulse)
hit_o  out  1  valid tag match in the addressed set
data_o  out  LINE_W  hit line, or LRU-victim line on miss
tag_o  out  TAG_W  tag of the line on data_o
valid_o  out  1  valid bit of the line on data_o
dirty_o  out  1  dirty bit of the line on data_o (write-back decision)
busy_o  out  1  flush sweep in progress
flush_done_o  out  1  one-cycle pulse on the final flush cycle

Behaviour:
- Reset (rst_i=0, asynchronous): all valid/dirty bits cleared; LRU age of way w in every set = w; FSM=IDLE; flush counter=0; busy_o=0; flush_done_o=0. Tag/data arrays are not reset.
- Outputs are combinational. When req_i=0 or busy_o=1: hit_o, valid_o, dirty_o=0; data_o, tag_o=0.
- Hit: way w hits when valid[set][w] && tag[set][w]==tag_i. At most one way hits; a duplicate-tag situation is illegal and is never created by the block.
- Victim choice: lowest-index invalid way; if all ways are valid, the way with age WAYS-1.
- Output select: hit ? hit way : victim way. Controller writes back when !hit_o && valid_o && dirty_o.
- Write (req_i&&write_i&&!busy_o): target = hit way if hit, else victim. At the clock edge store tag_i, data_i, valid=1, dirty=dirty_i, then do an LRU touch on the target. A hit write overwrites the line in place.
- Read hit: LRU touch only. Read miss: no state change.
- LRU touch of way t with old age a: age[t]=0; each way with age<a increments. Ages remain a permutation of 0..WAYS-1.
- Flush FSM, states IDLE and FLUSH:
  - IDLE to FLUSH on flush_i. Counter=0.
  - In FLUSH, each cycle clears valid/dirty for all ways of set cnt and restores its ages to w.
  - cnt==SETS-1: flush_done_o=1, return to IDLE, counter=0.
  - Latency: exactly SETS cycles. busy_o=1 throughout FLUSH.
  - Data is not written back; the controller must clean dirty lines before flushing.
- Simultaneous flush_i and req_i in IDLE: flush wins; the request is dropped with no state change.
- flush_i while in FLUSH: ignored.
- Reset asserted during FLUSH: immediate return to IDLE with all lines invalid.

Decomposition:
- Package dcache_pkg holds:
  - defaults DCACHE_WAYS, DCACHE_SETS, DCACHE_TAG_W, DCACHE_LINE_W
  - FSM state encoding {ST_IDLE, ST_FLUSH}
- Sub-module dcache_lru_set: one set's age vector. Inputs: touch enable, way, init. Output: LRU way. Instantiated SETS times, or once with the age array muxed by set.

Test Plan:
- Reset, then req_i=1, read, set 3, tag 0x1234 -> hit_o=0, valid_o=0, busy_o=0, data_o=0 while req_i=0.
- Write set 3, tag 0x1234, data 0xA5.., dirty_i=0; then read same set/tag -> hit_o=1, data_o=0xA5.., dirty_o=0. Read tag 0x1235 -> hit_o=0, victim is way 1 (invalid).
- Fill tags A, B into set 5 (WAYS=2); read A; lookup C -> hit_o=0, tag_o=B. Write C, then lookup B -> hit_o=0; A and C both hit.
- Write tag D to set 7 with dirty_i=1, then a second line; read-miss a third tag so the victim is D -> valid_o=1, dirty_o=1, tag_o=D.
- flush_i pulse with req_i=1 in the same cycle -> busy_o=1 for 16 cycles; flush_done_o high on cycle 16; no write occurs; afterwards every earlier tag misses. Repeat with WAYS=4, SETS=8 to check the 8-cycle sweep and full LRU rotation order.
- Drive rst_i low mid-flush (cycle 5) -> busy_o=0 asynchronously; after release, all sets miss and flush_i restarts a full sweep.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared defaults and FSM encoding for the N-way dcache storage array.
package dcache_pkg;

    localparam int unsigned DCACHE_WAYS   = 2;
    localparam int unsigned DCACHE_SETS   = 16;
    localparam int unsigned DCACHE_TAG_W  = 23;
    localparam int unsigned DCACHE_LINE_W = 256;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } dcache_state_e;

endpackage

// File: rtl/dcache_lru_set.sv
// True-LRU age vector for one cache set. Age 0 is most recently used,
// age WAYS-1 is the replacement candidate; ages always form a permutation.
module dcache_lru_set
    import dcache_pkg::*;
#(
    parameter int unsigned WAYS = DCACHE_WAYS,
    parameter int unsigned WW   = $clog2(WAYS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          touch_i,
    input  logic [WW-1:0] way_i,
    input  logic          init_i,
    output logic [WW-1:0] lru_o
);

    logic [WW-1:0] r_age [WAYS];

    // Age update: init restores identity order, touch makes way_i youngest
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                r_age[WW'(w)] <= WW'(w);
            end
        end else if (init_i) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                r_age[WW'(w)] <= WW'(w);
            end
        end else if (touch_i) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (WW'(w) == way_i) begin
                    r_age[WW'(w)] <= '0;
                end else if (r_age[WW'(w)] < r_age[way_i]) begin
                    r_age[WW'(w)] <= r_age[WW'(w)] + 1'b1;
                end
            end
        end
    end

    // Oldest way is the one carrying age WAYS-1
    always_comb begin
        lru_o = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (r_age[WW'(w)] == WW'(WAYS - 1)) begin
                lru_o = WW'(w);
            end
        end
    end

endmodule

// File: rtl/dcache_sram_nway.sv
// N-way set-associative dcache storage: combinational lookup, per-set
// true-LRU victim choice, valid/dirty tracking and an invalidate-all sweep.
module dcache_sram_nway
    import dcache_pkg::*;
#(
    parameter int unsigned WAYS   = DCACHE_WAYS,
    parameter int unsigned SETS   = DCACHE_SETS,
    parameter int unsigned TAG_W  = DCACHE_TAG_W,
    parameter int unsigned LINE_W = DCACHE_LINE_W,
    parameter int unsigned IDX_W  = $clog2(SETS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              write_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              dirty_i,
    input  logic              flush_i,
    output logic              hit_o,
    output logic [LINE_W-1:0] data_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic              valid_o,
    output logic              dirty_o,
    output logic              busy_o,
    output logic              flush_done_o
);

    localparam int unsigned WW = $clog2(WAYS);

    dcache_state_e     r_state;
    logic [IDX_W-1:0]  r_cnt;
    logic              r_done;
    logic [WAYS-1:0]   r_valid [SETS];
    logic [WAYS-1:0]   r_dirty [SETS];
    logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
    logic [LINE_W-1:0] r_data  [SETS][WAYS];

    logic              w_busy;
    logic              w_active;
    logic              w_hit;
    logic              w_found_inv;
    logic              w_write_en;
    logic              w_touch;
    logic [WW-1:0]     w_hit_way;
    logic [WW-1:0]     w_victim;
    logic [WW-1:0]     w_sel;
    logic [WW-1:0]     w_lru [SETS];
    logic [SETS-1:0]   w_set_touch;
    logic [SETS-1:0]   w_set_init;

    assign w_busy     = (r_state == ST_FLUSH);
    assign w_active   = req_i && !w_busy;
    // A flush request in the same cycle drops the access entirely
    assign w_write_en = w_active && !flush_i && write_i;
    assign w_touch    = w_active && !flush_i && (write_i || w_hit);

    // Tag compare and victim selection for the addressed set
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_found_inv = 1'b0;
        w_victim    = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (r_valid[addr_i][WW'(w)] && (r_tag[addr_i][WW'(w)] == tag_i)) begin
                w_hit     = 1'b1;
                w_hit_way = WW'(w);
            end
        end
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!w_found_inv && !r_valid[addr_i][WW'(w)]) begin
                w_found_inv = 1'b1;
                w_victim    = WW'(w);
            end
        end
        if (!w_found_inv) begin
            w_victim = w_lru[addr_i];
        end
        w_sel = w_hit ? w_hit_way : w_victim;
    end

    // Line presented to the controller, forced to zero when idle or sweeping
    always_comb begin
        hit_o   = 1'b0;
        data_o  = '0;
        tag_o   = '0;
        valid_o = 1'b0;
        dirty_o = 1'b0;
        if (w_active) begin
            hit_o   = w_hit;
            data_o  = r_data[addr_i][w_sel];
            tag_o   = r_tag[addr_i][w_sel];
            valid_o = r_valid[addr_i][w_sel];
            dirty_o = r_dirty[addr_i][w_sel];
        end
    end

    for (genvar s = 0; s < SETS; s++) begin : g_lru
        assign w_set_touch[s] = w_touch && (addr_i == IDX_W'(s));
        assign w_set_init[s]  = w_busy && (r_cnt == IDX_W'(s));

        dcache_lru_set #(
            .WAYS (WAYS)
        ) u_lru (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .touch_i (w_set_touch[s]),
            .way_i   (w_sel),
            .init_i  (w_set_init[s]),
            .lru_o   (w_lru[s])
        );
    end

    // Flush sequencer: one set per cycle, done pulse registered for the last set
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt  <= '0;
                    r_done <= 1'b0;
                    if (flush_i) begin
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (r_cnt == IDX_W'(SETS - 1)) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_done  <= 1'b0;
                    end else begin
                        r_cnt  <= r_cnt + 1'b1;
                        r_done <= (r_cnt == IDX_W'(SETS - 2));
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Valid/dirty bits: sweep clears a whole set, a write marks the target line
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                r_valid[IDX_W'(s)] <= '0;
                r_dirty[IDX_W'(s)] <= '0;
            end
        end else if (w_busy) begin
            r_valid[r_cnt] <= '0;
            r_dirty[r_cnt] <= '0;
        end else if (w_write_en) begin
            r_valid[addr_i][w_sel] <= 1'b1;
            r_dirty[addr_i][w_sel] <= dirty_i;
        end
    end

    // Tag and data storage, no reset
    always_ff @(posedge clk_i) begin
        if (w_write_en) begin
            r_tag[addr_i][w_sel]  <= tag_i;
            r_data[addr_i][w_sel] <= data_i;
        end
    end

    assign busy_o       = w_busy;
    assign flush_done_o = r_done;

endmodule

// File: tb/tb_dcache_sram_nway.sv
// Directed bench for dcache_sram_nway: default 2-way/16-set instance and a
// 4-way/8-set instance for the longer LRU rotation and shorter sweep.
module tb_dcache_sram_nway;

    int checks   = 0;
    int failures = 0;

    logic clk;
    logic rst_n;

    // Instance A: 2 ways, 16 sets, 256-bit lines
    logic         a_req, a_write, a_dirty, a_flush;
    logic [3:0]   a_addr;
    logic [22:0]  a_tag;
    logic [255:0] a_data;
    logic         a_hit, a_valid, a_dirty_o, a_busy, a_done;
    logic [255:0] a_data_o;
    logic [22:0]  a_tag_o;

    // Instance B: 4 ways, 8 sets, 32-bit lines
    logic         b_req, b_write, b_dirty, b_flush;
    logic [2:0]   b_addr;
    logic [22:0]  b_tag;
    logic [31:0]  b_data;
    logic         b_hit, b_valid, b_dirty_o, b_busy, b_done;
    logic [31:0]  b_data_o;
    logic [22:0]  b_tag_o;

    localparam logic [255:0] D_A5 = {32{8'hA5}};
    localparam logic [255:0] D_LA = {32{8'h1A}};
    localparam logic [255:0] D_LB = {32{8'h1B}};
    localparam logic [255:0] D_LC = {32{8'h1C}};
    localparam logic [255:0] D_LD = {32{8'hD0}};
    localparam logic [255:0] D_LE = {32{8'hE0}};
    localparam logic [255:0] D_E2 = {32{8'hE2}};

    localparam logic [22:0] T_A = 23'h0AAA;
    localparam logic [22:0] T_B = 23'h0BBB;
    localparam logic [22:0] T_C = 23'h0CCC;
    localparam logic [22:0] T_D = 23'h0DDD;
    localparam logic [22:0] T_E = 23'h0EEE;
    localparam logic [22:0] T_F = 23'h0FFF;

    dcache_sram_nway u_dut_a (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .req_i        (a_req),
        .write_i      (a_write),
        .addr_i       (a_addr),
        .tag_i        (a_tag),
        .data_i       (a_data),
        .dirty_i      (a_dirty),
        .flush_i      (a_flush),
        .hit_o        (a_hit),
        .data_o       (a_data_o),
        .tag_o        (a_tag_o),
        .valid_o      (a_valid),
        .dirty_o      (a_dirty_o),
        .busy_o       (a_busy),
        .flush_done_o (a_done)
    );

    dcache_sram_nway #(
        .WAYS   (4),
        .SETS   (8),
        .TAG_W  (23),
        .LINE_W (32)
    ) u_dut_b (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .req_i        (b_req),
        .write_i      (b_write),
        .addr_i       (b_addr),
        .tag_i        (b_tag),
        .data_i       (b_data),
        .dirty_i      (b_dirty),
        .flush_i      (b_flush),
        .hit_o        (b_hit),
        .data_o       (b_data_o),
        .tag_o        (b_tag_o),
        .valid_o      (b_valid),
        .dirty_o      (b_dirty_o),
        .busy_o       (b_busy),
        .flush_done_o (b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one access at the falling edge; it commits at the following rising edge
    task automatic a_op(input logic wr, input logic [3:0] set, input logic [22:0] tag,
                        input logic [255:0] d, input logic dty);
        @(negedge clk);
        a_req = 1'b1; a_write = wr; a_addr = set; a_tag = tag; a_data = d; a_dirty = dty; a_flush = 1'b0;
        #1;
    endtask

    task automatic b_op(input logic wr, input logic [2:0] set, input logic [22:0] tag,
                        input logic [31:0] d);
        @(negedge clk);
        b_req = 1'b1; b_write = wr; b_addr = set; b_tag = tag; b_data = d; b_dirty = 1'b0; b_flush = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (a_hit !== 1'b0) begin failures++; $display("FAIL rst_hit got=%b exp=0", a_hit); end
        checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", a_valid); end
        checks++; if (a_data_o !== 256'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", a_data_o); end
        checks++; if (a_tag_o !== 23'h0) begin failures++; $display("FAIL rst_tag got=%h exp=0", a_tag_o); end
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", a_busy); end
        checks++; if (a_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", a_done); end
        checks++; if (b_busy !== 1'b0) begin failures++; $display("FAIL rst_busy_b got=%b exp=0", b_busy); end
        a_op(1'b0, 4'd3, 23'h1234, '0, 1'b0);
        checks++; if (a_hit !== 1'b0) begin failures++; $display("FAIL rst_rd_hit got=%b exp=0", a_hit); end
        checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL rst_rd_valid got=%b exp=0", a_valid); end
        checks++; if (a_dirty_o !== 1'b0) begin failures++; $display("FAIL rst_rd_dirty got=%b exp=0", a_dirty_o); end
    endtask

    task automatic test_write_read;
        a_op(1'b1, 4'd3, 23'h1234, D_A5, 1'b0);
        a_op(1'b0, 4'd3, 23'h1234, '0, 1'b0);
        checks++; if (a_hit !== 1'b1) begin failures++; $display("FAIL wr_rd_hit got=%b exp=1", a_hit); end
        checks++; if (a_data_o !== D_A5) begin failures++; $display("FAIL wr_rd_data got=%h exp=%h", a_data_o, D_A5); end
        checks++; if (a_dirty_o !== 1'b0) begin failures++; $display("FAIL wr_rd_dirty got=%b exp=0", a_dirty_o); end
        checks++; if (a_tag_o !== 23'h1234) begin failures++; $display("FAIL wr_rd_tag got=%h exp=1234", a_tag_o); end
        a_op(1'b0, 4'd3, 23'h1235, '0, 1'b0);
        checks++; if (a_hit !== 1'b0) begin failures++; $display("FAIL miss_hit got=%b exp=0", a_hit); end
        checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL miss_inv_victim valid got=%b exp=0", a_valid); end
    endtask

    task automatic test_lru;
        a_op(1'b1, 4'd5, T_A, D_LA, 1'b0);
        a_op(1'b1, 4'd5, T_B, D_LB, 1'b0);
        a_op(1'b0, 4'd5, T_A, '0, 1'b0);
        checks++; if (a_hit !== 1'b1) begin failures++; $display("FAIL lru_rdA_hit got=%b exp=1", a_hit); end
        a_op(1'b0, 4'd5, T_C, '0, 1'b0);
        checks++; if (a_hit !== 1'b0) begin failures++; $display("FAIL lru_C_hit got=%b exp=0", a_hit); end
        checks++; if (a_tag_o !== T_B) begin failures++; $display("FAIL lru_victim_tag got=%h exp=%h", a_tag_o, T_B); end
        checks++; if (a_valid !== 1'b1) begin failures++; $display("FAIL lru_victim_valid got=%b exp=1", a_valid); end
        a_op(1'b1, 4'd5, T_C, D_LC, 1'b0);
        a_op(1'b0, 4'd5, T_B, '0, 1'b0);
        checks++; if (a_hit !== 1'b0) begin failures++; $display("FAIL lru_B_evicted got=%b exp=0", a_hit); end
        checks++; if (a_tag_o !== T_A) begin failures++; $display("FAIL lru_victim2_tag got=%h exp=%h", a_tag_o, T_A); end
        a_op(1'b0, 4'd5, T_A, '0, 1'b0);
        checks++; if (a_hit !== 1'b1) begin failures++; $display("FAIL lru_A_kept got=%b exp=1", a_hit); end
        checks++; if (a_data_o !== D_LA) begin failures++; $display("FAIL lru_A_data got=%h exp=%h", a_data_o, D_LA); end
        a_op(1'b0, 4'd5, T_C, '0, 1'b0);
        checks++; if (a_hit !== 1'b1) begin failures++; $display("FAIL lru_C_hit2 got=%b exp=1", a_hit); end
        checks++; if (a_data_o !== D_LC) begin failures++; $display("FAIL lru_C_data got=%h exp=%h", a_data_o, D_LC); end
    endtask

    task automatic test_dirty_victim;
        a_op(1'b1, 4'd7, T_D, D_LD, 1'b1);
        a_op(1'b1, 4'd7, T_E, D_LE, 1'b0);
        a_op(1'b0, 4'd7, T_F, '0, 1'b0);
        checks++; if (a_hit !== 1'b0) begin failures++; $display("FAIL dv_hit got=%b exp=0", a_hit); end
        checks++; if (a_valid !== 1'b1) begin failures++; $display("FAIL dv_valid got=%b exp=1", a_valid); end
        checks++; if (a_dirty_o !== 1'b1) begin failures++; $display("FAIL dv_dirty got=%b exp=1", a_dirty_o); end
        checks++; if (a_tag_o !== T_D) begin failures++; $display("FAIL dv_tag got=%h exp=%h", a_tag_o, T_D); end
        checks++; if (a_data_o !== D_LD) begin failures++; $display("FAIL dv_data got=%h exp=%h", a_data_o, D_LD); end
        a_op(1'b1, 4'd7, T_E, D_E2, 1'b1);
        a_op(1'b0, 4'd7, T_E, '0, 1'b0);
        checks++; if (a_hit !== 1'b1) begin failures++; $display("FAIL inplace_hit got=%b exp=1", a_hit); end
        checks++; if (a_data_o !== D_E2) begin failures++; $display("FAIL inplace_data got=%h exp=%h", a_data_o, D_E2); end
        checks++; if (a_dirty_o !== 1'b1) begin failures++; $display("FAIL inplace_dirty got=%b exp=1", a_dirty_o); end
        a_op(1'b0, 4'd7, T_D, '0, 1'b0);
        checks++; if (a_hit !== 1'b1) begin failures++; $display("FAIL inplace_D_kept got=%b exp=1", a_hit); end
    endtask

    task automatic test_flush_a;
        int busy_cnt;
        int done_cnt;
        int done_at;
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        // Flush together with a write request: flush wins, write dropped
        @(negedge clk);
        a_req = 1'b1; a_write = 1'b1; a_addr = 4'd9; a_tag = 23'h0777; a_data = D_A5; a_dirty = 1'b1; a_flush = 1'b1;
        @(negedge clk);
        a_flush = 1'b0; a_write = 1'b0; a_addr = 4'd3; a_tag = 23'h1234;
        #1;
        // Set 3 still holds 0x1234 here; outputs must be gated by busy
        checks++; if (a_hit !== 1'b0) begin failures++; $display("FAIL busy_gate_hit got=%b exp=0", a_hit); end
        checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL busy_gate_valid got=%b exp=0", a_valid); end
        checks++; if (a_data_o !== 256'h0) begin failures++; $display("FAIL busy_gate_data got=%h exp=0", a_data_o); end
        for (int i = 0; i < 20; i++) begin
            if (i > 0) begin
                @(negedge clk);
                a_req = 1'b0;
                a_flush = (i == 5);
                #1;
            end
            if (a_busy) busy_cnt++;
            if (a_done) begin
                done_cnt++;
                done_at = i;
            end
        end
        a_flush = 1'b0;
        checks++; if (busy_cnt != 16) begin failures++; $display("FAIL flushA_busy_cycles got=%0d exp=16", busy_cnt); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL flushA_done_pulses got=%0d exp=1", done_cnt); end
        checks++; if (done_at != 15) begin failures++; $display("FAIL flushA_done_cycle got=%0d exp=15", done_at); end
        a_op(1'b0, 4'd3, 23'h1234, '0, 1'b0);
        checks++; if (a_hit !== 1'b0) begin failures++; $display("FAIL postflush_s3 got=%b exp=0", a_hit); end
        checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL postflush_s3_valid got=%b exp=0", a_valid); end
        a_op(1'b0, 4'd5, T_A, '0, 1'b0);
        checks++; if (a_hit !== 1'b0) begin failures++; $display("FAIL postflush_A got=%b exp=0", a_hit); end
        a_op(1'b0, 4'd5, T_C, '0, 1'b0);
        checks++; if (a_hit !== 1'b0) begin failures++; $display("FAIL postflush_C got=%b exp=0", a_hit); end
        a_op(1'b0, 4'd7, T_D, '0, 1'b0);
        checks++; if (a_hit !== 1'b0) begin failures++; $display("FAIL postflush_D got=%b exp=0", a_hit); end
        checks++; if (a_dirty_o !== 1'b0) begin failures++; $display("FAIL postflush_D_dirty got=%b exp=0", a_dirty_o); end
        a_op(1'b0, 4'd9, 23'h0777, '0, 1'b0);
        checks++; if (a_hit !== 1'b0) begin failures++; $display("FAIL postflush_dropped_wr got=%b exp=0", a_hit); end
        @(negedge clk);
        a_req = 1'b0;
    endtask

    task automatic test_flush_b;
        int busy_cnt;
        int done_cnt;
        int done_at;
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        b_op(1'b1, 3'd2, 23'h100, 32'hD0000000);
        b_op(1'b1, 3'd2, 23'h101, 32'hD0000001);
        b_op(1'b1, 3'd2, 23'h102, 32'hD0000002);
        b_op(1'b1, 3'd2, 23'h103, 32'hD0000003);
        b_op(1'b0, 3'd2, 23'h102, '0);
        checks++; if (b_hit !== 1'b1) begin failures++; $display("FAIL b_rdT2_hit got=%b exp=1", b_hit); end
        checks++; if (b_data_o !== 32'hD0000002) begin failures++; $display("FAIL b_rdT2_data got=%h exp=D0000002", b_data_o); end
        b_op(1'b0, 3'd2, 23'h109, '0);
        checks++; if (b_tag_o !== 23'h100) begin failures++; $display("FAIL b_victim1 got=%h exp=100", b_tag_o); end
        checks++; if (b_valid !== 1'b1) begin failures++; $display("FAIL b_victim1_valid got=%b exp=1", b_valid); end
        b_op(1'b1, 3'd2, 23'h109, 32'hD0000009);
        b_op(1'b0, 3'd2, 23'h100, '0);
        checks++; if (b_hit !== 1'b0) begin failures++; $display("FAIL b_T0_evicted got=%b exp=0", b_hit); end
        checks++; if (b_tag_o !== 23'h101) begin failures++; $display("FAIL b_victim2 got=%h exp=101", b_tag_o); end
        b_op(1'b0, 3'd2, 23'h103, '0);
        checks++; if (b_hit !== 1'b1) begin failures++; $display("FAIL b_rdT3_hit got=%b exp=1", b_hit); end
        b_op(1'b0, 3'd2, 23'h101, '0);
        checks++; if (b_hit !== 1'b1) begin failures++; $display("FAIL b_rdT1_hit got=%b exp=1", b_hit); end
        b_op(1'b0, 3'd2, 23'h107, '0);
        checks++; if (b_tag_o !== 23'h102) begin failures++; $display("FAIL b_victim3 got=%h exp=102", b_tag_o); end
        @(negedge clk);
        b_req = 1'b0; b_flush = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            b_flush = 1'b0;
            #1;
            if (b_busy) busy_cnt++;
            if (b_done) begin
                done_cnt++;
                done_at = i;
            end
        end
        checks++; if (busy_cnt != 8) begin failures++; $display("FAIL flushB_busy_cycles got=%0d exp=8", busy_cnt); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL flushB_done_pulses got=%0d exp=1", done_cnt); end
        checks++; if (done_at != 7) begin failures++; $display("FAIL flushB_done_cycle got=%0d exp=7", done_at); end
        b_op(1'b0, 3'd2, 23'h109, '0);
        checks++; if (b_hit !== 1'b0) begin failures++; $display("FAIL b_postflush_T9 got=%b exp=0", b_hit); end
        checks++; if (b_valid !== 1'b0) begin failures++; $display("FAIL b_postflush_valid got=%b exp=0", b_valid); end
        @(negedge clk);
        b_req = 1'b0;
    endtask

    task automatic test_reset_mid_flush;
        int busy_cnt;
        int done_at;
        busy_cnt = 0; done_at = -1;
        a_op(1'b1, 4'd12, 23'h0C0C, D_A5, 1'b1);
        a_op(1'b0, 4'd12, 23'h0C0C, '0, 1'b0);
        checks++; if (a_hit !== 1'b1) begin failures++; $display("FAIL rmf_pre_hit got=%b exp=1", a_hit); end
        @(negedge clk);
        a_req = 1'b0; a_flush = 1'b1;
        @(negedge clk);
        a_flush = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL rmf_async_busy got=%b exp=0", a_busy); end
        checks++; if (a_done !== 1'b0) begin failures++; $display("FAIL rmf_async_done got=%b exp=0", a_done); end
        @(negedge clk);
        rst_n = 1'b1;
        a_op(1'b0, 4'd12, 23'h0C0C, '0, 1'b0);
        checks++; if (a_hit !== 1'b0) begin failures++; $display("FAIL rmf_post_hit got=%b exp=0", a_hit); end
        checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL rmf_post_valid got=%b exp=0", a_valid); end
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL rmf_post_busy got=%b exp=0", a_busy); end
        @(negedge clk);
        a_req = 1'b0; a_flush = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            a_flush = 1'b0;
            #1;
            if (a_busy) busy_cnt++;
            if (a_done) done_at = i;
        end
        checks++; if (busy_cnt != 16) begin failures++; $display("FAIL rmf_resweep_cycles got=%0d exp=16", busy_cnt); end
        checks++; if (done_at != 15) begin failures++; $display("FAIL rmf_resweep_done got=%0d exp=15", done_at); end
    endtask

    initial begin
        rst_n = 1'b0;
        a_req = 1'b0; a_write = 1'b0; a_addr = '0; a_tag = '0; a_data = '0; a_dirty = 1'b0; a_flush = 1'b0;
        b_req = 1'b0; b_write = 1'b0; b_addr = '0; b_tag = '0; b_data = '0; b_dirty = 1'b0; b_flush = 1'b0;
        test_reset();
        test_write_read();
        test_lru();
        test_dirty_victim();
        test_flush_a();
        test_flush_b();
        test_reset_mid_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
